seg_bcd_converter: RTL

//  Sequential signed-binary to BCD converter (shift-add-3 / double-dabble) that feeds the per-digit 7-seg decoders.

---
 rtl/seg_pkg.sv | 26 ++
 rtl/seg_sign_blank.sv | 51 +++++
 rtl/seg_bcd_converter.sv | 123 ++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared types and constants for the signed-binary to BCD display path.
// Digit codes: 0-9 numerals, DIG_BLANK (minus when signed), DIG_OVF overflow glyph.
package seg_pkg;

   typedef logic [3:0] digit_t;

   localparam digit_t DIG_BLANK = 4'd10;
   localparam digit_t DIG_OVF   = 4'd15;

   typedef enum logic [1:0] {
      IDLE,
      CONVERT,
      BLANK
   } conv_state_t;

   // Elaboration-time helper for the displayable-range limits.
   function automatic int unsigned pow10(input int unsigned n);
      int unsigned r;
      r = 1;
      for (int unsigned i = 0; i < n; i++) begin
         r = r * 10;
      end
      return r;
   endfunction

endpackage

// File: rtl/seg_sign_blank.sv
// Combinational digit post-processing: overflow glyph, sign placement, optional
// leading-zero blanking (enabled by defining LEAD_ZERO_BLANK_EN).
module seg_sign_blank
   import seg_pkg::*;
#(
   parameter int NUM_DIGITS = 4
) (
   input  logic [4*NUM_DIGITS-1:0] bcd,
   input  logic                    neg,
   input  logic                    ovf,
   output logic [4*NUM_DIGITS-1:0] digits,
   output logic [NUM_DIGITS-1:0]   sign_mask
);

`ifdef LEAD_ZERO_BLANK_EN
   // lz[i]: digit i and everything above it are zero; digit 0 is never a leading zero.
   logic [NUM_DIGITS:0] lz;
`endif

   // NOTE: every output gets a default at the top of always_comb so no path can infer a latch.
   always_comb begin
      digits    = bcd;
      sign_mask = '0;
`ifdef LEAD_ZERO_BLANK_EN
      lz             = '0;
      lz[NUM_DIGITS] = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         lz[i] = lz[i+1] && (bcd[4*i +: 4] == 4'd0);
      end
      for (int i = 1; i < NUM_DIGITS; i++) begin
         if (lz[i]) begin
            digits[4*i +: 4] = DIG_BLANK;
         end
         // Minus sits in the first blanked position directly left of the MSD.
         if (neg && lz[i] && !lz[i-1]) begin
            sign_mask[i] = 1'b1;
         end
      end
`else
      if (neg) begin
         digits[4*(NUM_DIGITS-1) +: 4] = DIG_BLANK;
         sign_mask[NUM_DIGITS-1]       = 1'b1;
      end
`endif
      if (ovf) begin
         digits    = {NUM_DIGITS{DIG_OVF}};
         sign_mask = '0;
      end
   end

endmodule

// File: rtl/seg_bcd_converter.sv
// Sequential signed-binary to BCD converter (shift-add-3) for the 7-seg decoder bank.
// Optional build macro LEAD_ZERO_BLANK_EN (see seg_sign_blank) blanks leading zeros.
module seg_bcd_converter
   import seg_pkg::*;
#(
   parameter int DATA_W     = 12,
   parameter int NUM_DIGITS = 4
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    start,
   input  logic [DATA_W-1:0]       din,
   output logic                    busy,
   output logic                    done,
   output logic [4*NUM_DIGITS-1:0] digits,
   output logic [NUM_DIGITS-1:0]   sign_mask,
   output logic                    ovf
);

   localparam int          BCD_W   = 4 * NUM_DIGITS;
   localparam logic [31:0] POS_MAX = 32'(pow10(NUM_DIGITS) - 1);
   localparam logic [31:0] NEG_MAX = 32'(pow10(NUM_DIGITS - 1) - 1);

   conv_state_t state, state_nxt;

   logic [4:0]        cnt;
   logic [DATA_W-1:0] mag;
   logic [DATA_W-1:0] mag_in;
   logic [BCD_W-1:0]  bcd;
   logic [BCD_W-1:0]  bcd_adj;
   logic              neg;
   logic              ovf_pend;
   logic              accept;
   logic              last_bit;

   logic [BCD_W-1:0]      sb_digits;
   logic [NUM_DIGITS-1:0] sb_sign_mask;

   assign accept   = (state == IDLE) && start;
   assign last_bit = (cnt == 5'(DATA_W - 1));
   assign busy     = (state != IDLE);

   // Two's-complement magnitude; the most negative input maps to 2^(DATA_W-1), which still fits.
   assign mag_in = din[DATA_W-1] ? (~din + DATA_W'(1)) : din;

   always_comb begin
      bcd_adj = bcd;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (bcd[4*i +: 4] >= 4'd5) begin
            bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
         end
      end
   end

   // NOTE: reset is asynchronous so the converter abandons a conversion the instant reset_n falls.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (start)    state_nxt = CONVERT;
         CONVERT: if (last_bit) state_nxt = BLANK;
         BLANK:                 state_nxt = IDLE;
         default:               state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt      <= '0;
         mag      <= '0;
         bcd      <= '0;
         neg      <= 1'b0;
         ovf_pend <= 1'b0;
      end else if (accept) begin
         cnt      <= '0;
         mag      <= mag_in;
         bcd      <= '0;
         neg      <= din[DATA_W-1];
         ovf_pend <= din[DATA_W-1] ? (32'(mag_in) > NEG_MAX) : (32'(mag_in) > POS_MAX);
      end else if (state == CONVERT) begin
         cnt <= cnt + 5'd1;
         mag <= mag << 1;
         // The adjusted top nibble's MSB falls off; it is never set for in-range values.
         bcd <= BCD_W'({bcd_adj, mag[DATA_W-1]});
      end
   end

   seg_sign_blank #(
      .NUM_DIGITS (NUM_DIGITS)
   ) u_sign_blank (
      .bcd       (bcd),
      .neg       (neg),
      .ovf       (ovf_pend),
      .digits    (sb_digits),
      .sign_mask (sb_sign_mask)
   );

   // Display outputs change only at the BLANK->IDLE edge, together with done.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         done      <= 1'b0;
         digits    <= {NUM_DIGITS{DIG_BLANK}};
         sign_mask <= '0;
         ovf       <= 1'b0;
      end else begin
         done <= (state == BLANK);
         if (state == BLANK) begin
            digits    <= sb_digits;
            sign_mask <= sb_sign_mask;
            ovf       <= ovf_pend;
         end
      end
   end

endmodule
